// File: rtl/requant_drain_pkg.sv
// Shared definitions for the requantisation drain and the CFU that hosts it:
// FSM encodings, lane count and int8 clamp bounds.
package requant_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int LANES = 4;
    localparam logic signed [32:0] CLAMP_MIN = -33'sd128;
    localparam logic signed [32:0] CLAMP_MAX = 33'sd127;

    // Lane 0 occupies the most significant word of a 128-bit row.
    function automatic logic [31:0] lane_word(input logic [127:0] v, input int i);
        return v[127-32*i -: 32];
    endfunction

endpackage

// File: rtl/requant_lane.sv
// Combinational per-lane datapath: SRDHM + rounding shift (S2 path) and
// offset + int8 clamp (S3 path); the two paths are separated by top-level registers.
module requant_lane
    import requant_drain_pkg::*;
(
    input  logic [63:0] prod,
    input  logic        sat,
    input  logic [4:0]  shift,
    output logic [31:0] r,
    input  logic [31:0] r_in,
    input  logic [31:0] out_offset,
    output logic [7:0]  y
);

    logic signed [63:0] nudged;
    logic signed [63:0] biased;
    logic [31:0]        m;
    logic [31:0]        mask;
    logic [31:0]        rem;
    logic [31:0]        thr;
    logic signed [32:0] sum;
    logic               unused_bits;

    always_comb begin
        nudged = $signed(prod) + (prod[63] ? (64'sd1 - 64'sd1073741824) : 64'sd1073741824);
        // Adding 2^31-1 before the arithmetic shift turns floor into truncation toward zero.
        biased = nudged[63] ? (nudged + 64'sd2147483647) : nudged;
        m      = sat ? 32'h7FFF_FFFF : biased[62:31];

        mask = (32'd1 << shift) - 32'd1;
        rem  = m & mask;
        thr  = (mask >> 1) + {31'd0, m[31]};
        r    = 32'($signed(m) >>> shift) + {31'd0, (rem > thr)};

        sum = $signed({r_in[31], r_in}) + $signed({out_offset[31], out_offset});
        if (sum < CLAMP_MIN) begin
            y = CLAMP_MIN[7:0];
        end else if (sum > CLAMP_MAX) begin
            y = CLAMP_MAX[7:0];
        end else begin
            y = sum[7:0];
        end
    end

    assign unused_bits = ^{biased[63], biased[30:0]};

endmodule

// File: rtl/requant_drain.sv
// Drains gbuff_C rows through bias/SRDHM/RDBPOT/clamp and streams packed int8 words
// out through a small FIFO, issuing reads only when the FIFO can absorb every row in flight.
//
// state    | meaning
// ---------|---------------------------------------------------------
// ST_IDLE  | waiting for start; config inputs are latched on accept
// ST_RUN   | issuing gbuff_C reads as FIFO credit allows
// ST_FLUSH | all reads issued; waiting for the last word to be taken
module requant_drain
    import requant_drain_pkg::*;
#(
    parameter int ADDR_BITS  = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] num_rows,
    input  logic [127:0]         bias,
    input  logic [31:0]          multiplier,
    input  logic [4:0]           shift,
    input  logic [31:0]          out_offset,
    output logic [ADDR_BITS-1:0] c_index,
    input  logic [127:0]         c_data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic                 busy,
    output logic                 done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    state_t state, state_nxt;

    logic [ADDR_BITS-1:0] nrows_q;
    logic [127:0]         bias_q;
    logic [31:0]          mult_q;
    logic [31:0]          offset_q;
    logic [4:0]           shift_q;

    logic accept, rd_en, last_pop, done_zero_q;
    logic push, pop;
    logic v0, v1, v2;
    logic [1:0]       inflight;
    logic [CNT_W+1:0] occupancy;
    logic [31:0]      pack_d;

    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    assign accept   = (state == ST_IDLE) && start;
    assign inflight = {1'b0, v0} + {1'b0, v1} + {1'b0, v2};
    assign push     = v2;
    assign out_valid = (count != '0);
    assign pop      = out_valid && out_ready;
    assign out_data = fifo_mem[rd_ptr];
    assign done     = done_zero_q || last_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = (state != ST_IDLE);
        // Credit counts the word leaving this cycle so a full-rate stream never stalls.
        occupancy = {2'b00, count} - {{(CNT_W+1){1'b0}}, pop} + {{CNT_W{1'b0}}, inflight};
        last_pop  = (state == ST_FLUSH) && pop && (count == CNT_W'(1)) && (inflight == 2'd0);
        case (state)
            ST_IDLE: begin
                if (start && (num_rows != '0)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                rd_en = (occupancy < (CNT_W+2)'(FIFO_DEPTH));
                if (rd_en && (c_index == nrows_q - ADDR_BITS'(1))) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (last_pop) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            nrows_q  <= num_rows;
            bias_q   <= bias;
            mult_q   <= multiplier;
            shift_q  <= shift;
            offset_q <= out_offset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_index     <= '0;
            v0          <= 1'b0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            done_zero_q <= 1'b0;
        end else begin
            if (accept) begin
                c_index <= '0;
            end else if (rd_en) begin
                c_index <= c_index + ADDR_BITS'(1);
            end
            v0          <= rd_en;
            v1          <= v0;
            v2          <= v1;
            done_zero_q <= accept && (num_rows == '0);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [31:0] s_d;
        logic [63:0] prod_d;
        logic [63:0] prod_q;
        logic        sat_q;
        logic [31:0] r_d;
        logic [31:0] r_q;
        logic [7:0]  y_d;

        assign s_d    = lane_word(c_data_out, i) + lane_word(bias_q, i);
        assign prod_d = 64'($signed(s_d)) * 64'($signed(mult_q));

        always_ff @(posedge clk) begin
            prod_q <= prod_d;
            sat_q  <= (s_d == 32'h8000_0000) && (mult_q == 32'h8000_0000);
            r_q    <= r_d;
        end

        requant_lane u_lane (
            .prod       (prod_q),
            .sat        (sat_q),
            .shift      (shift_q),
            .r          (r_d),
            .r_in       (r_q),
            .out_offset (offset_q),
            .y          (y_d)
        );

        assign pack_d[8*i +: 8] = y_d;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= pack_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_requant_drain.sv
// Directed bench for requant_drain: hand-computed int8 words, latency,
// back-pressure stall, empty job and mid-run reset.
module tb_requant_drain;

    localparam int AB = 12;

    logic          clk = 1'b0;
    logic          reset, start, out_ready;
    logic [AB-1:0] num_rows, c_index;
    logic [127:0]  bias, c_data_out;
    logic [31:0]   multiplier, out_offset, out_data;
    logic [4:0]    shift;
    logic          out_valid, busy, done;

    logic [127:0]  bram [16];
    logic [31:0]   got_q [$];
    int            cyc = 0, start_cyc = 0, first_valid_cyc = -1, done_cnt = 0;
    int            n_checks = 0, n_fail = 0;

    requant_drain #(.ADDR_BITS(AB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows), .bias(bias),
        .multiplier(multiplier), .shift(shift), .out_offset(out_offset),
        .c_index(c_index), .c_data_out(c_data_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        c_data_out <= bram[c_index[3:0]];
    end

    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pack4(input logic [31:0] a0, a1, a2, a3);
        return {a0, a1, a2, a3};
    endfunction

    task automatic launch(input int n, input logic [127:0] b, input logic [31:0] m,
                          input logic [4:0] s, input logic [31:0] o);
        got_q.delete();
        done_cnt = 0;
        first_valid_cyc = -1;
        start_cyc = cyc;
        start = 1'b1;
        num_rows = AB'(n);
        bias = b;
        multiplier = m;
        shift = s;
        out_offset = o;
        tick();
        // Junk config after the start edge must not affect the job.
        start = 1'b0;
        num_rows = AB'(3);
        bias = {4{32'h0001_2345}};
        multiplier = 32'h1234_5678;
        shift = 5'd7;
        out_offset = 32'h55;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            tick();
            k++;
        end
        repeat (3) tick();
        chk({tag, " done_count"}, 64'(done_cnt), 64'd1);
    endtask

    task automatic chk_words(input string tag, input logic [31:0] exp [$]);
        chk({tag, " word_count"}, 64'(got_q.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s word%0d", tag, i), (i < got_q.size()) ? 64'(got_q[i]) : 'x, 64'(exp[i]));
    endtask

    logic [31:0] exp_q [$];

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b1; num_rows = '0; bias = '0;
        multiplier = '0; shift = '0; out_offset = '0;
        for (int i = 0; i < 16; i++) bram[i] = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset c_index", 64'(c_index), 64'd0);

        // A: halving multiplier with round-half-away and negative clamp
        bram[0] = pack4(10, -10, 100, -300);
        launch(1, '0, 32'h4000_0000, 5'd0, 32'd0);
        chk("A busy", 64'(busy), 64'd1);
        wait_done("A", 30);
        chk("A latency", 64'(first_valid_cyc - start_cyc), 64'd5);
        exp_q = '{32'h8032_FB05};
        chk_words("A", exp_q);

        // B: near-unity multiplier with rounding shift of 2
        bram[0] = pack4(10, -10, 0, 4);
        launch(1, '0, 32'h7FFF_FFFF, 5'd2, 32'd0);
        wait_done("B", 30);
        exp_q = '{32'h0100_FD03};
        chk_words("B", exp_q);

        // C: SRDHM saturation corner
        bram[0] = pack4(32'h8000_0000, 0, 0, 0);
        launch(1, '0, 32'h8000_0000, 5'd0, 32'd0);
        wait_done("C", 30);
        exp_q = '{32'h0000_007F};
        chk_words("C", exp_q);

        // D: per-lane bias, shift 1, offset 3 -> s={10,-10,0,104}, m={5,-5,0,52}
        bram[0] = pack4(1, 2, 3, 4);
        launch(1, pack4(9, -12, -3, 100), 32'h4000_0000, 5'd1, 32'd3);
        wait_done("D", 30);
        exp_q = '{32'h1D03_0006};
        chk_words("D", exp_q);

        // E: 8 rows with out_ready held low for the first 12 cycles
        for (int i = 0; i < 8; i++) bram[i] = pack4(2*i, -2*i, 0, 254);
        out_ready = 1'b0;
        launch(8, '0, 32'h4000_0000, 5'd0, 32'd0);
        repeat (10) tick();
        chk("E stall c_index", 64'(c_index), 64'd4);
        chk("E stall out_valid", 64'(out_valid), 64'd1);
        chk("E stall busy", 64'(busy), 64'd1);
        tick();
        out_ready = 1'b1;
        wait_done("E", 60);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({8'h7F, 8'h00, 8'(-i), 8'(i)});
        chk_words("E", exp_q);

        // F: empty job
        launch(0, '0, 32'h4000_0000, 5'd0, 32'd0);
        chk("F done", 64'(done), 64'd1);
        chk("F busy", 64'(busy), 64'd0);
        tick();
        chk("F done_low", 64'(done), 64'd0);
        repeat (6) tick();
        chk("F no_valid", 64'(first_valid_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("F done_count", 64'(done_cnt), 64'd1);

        // G: reset three cycles after start, then a clean rerun
        launch(6, '0, 32'h4000_0000, 5'd0, 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("G busy", 64'(busy), 64'd0);
        chk("G out_valid", 64'(out_valid), 64'd0);
        chk("G c_index", 64'(c_index), 64'd0);
        reset = 1'b0;
        repeat (10) tick();
        chk("G discarded_words", 64'(got_q.size()), 64'd0);
        chk("G no_done", 64'(done_cnt), 64'd0);
        launch(6, '0, 32'h4000_0000, 5'd0, 32'd0);
        wait_done("G2", 60);
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back({8'h7F, 8'h00, 8'(-i), 8'(i)});
        chk_words("G2", exp_q);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
